// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
//   Ramps a registered PWM duty value toward a live target. The duty moves by
//   a fixed step once every 'interval' cycles. With ramp_en low the block is
//   bypassed and duty_out follows target_duty with one cycle of latency.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   ramp_en      1 = ramp toward target, 0 = bypass (duty_out <= target_duty)
//   hold         1 = freeze interval counter, duty and state (ignored in bypass)
//   target_duty  requested duty, sampled every cycle
//   step_size    duty change per step (0 behaves as 1)
//   interval     clock cycles per step (0 behaves as 1)
//   duty_out     registered duty value to the PWM peripheral
//   busy         registered, high while ramping
//   done         registered one-cycle pulse when a ramp reaches its target
module pwm_ramp_controller #(
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ramp_en,
    input  logic                  hold,
    input  logic [7:0]            target_duty,
    input  logic [7:0]            step_size,
    input  logic [INTERVAL_W-1:0] interval,
    output logic [7:0]            duty_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t                state;
    logic [INTERVAL_W-1:0] cnt;
    logic [INTERVAL_W-1:0] eff_interval;
    logic [7:0]            eff_step;
    logic [8:0]            up_sum;
    logic signed [9:0]     dn_diff;
    logic [7:0]            next_duty;
    logic                  step_evt;

    always_comb begin
        eff_interval = (interval == '0) ? INTERVAL_W'(1) : interval;
        eff_step     = (step_size == '0) ? 8'd1 : step_size;
        // Wide arithmetic so the step clamps at the target instead of wrapping.
        up_sum       = {1'b0, duty_out} + {1'b0, eff_step};
        dn_diff      = $signed({2'b00, duty_out}) - $signed({2'b00, eff_step});
        next_duty    = duty_out;
        if (duty_out < target_duty) begin
            next_duty = (up_sum > {1'b0, target_duty}) ? target_duty : up_sum[7:0];
        end else if (duty_out > target_duty) begin
            next_duty = (dn_diff < $signed({2'b00, target_duty})) ? target_duty : dn_diff[7:0];
        end
        // ">=" so a shortened interval mid-ramp steps on the very next edge.
        step_evt     = (cnt >= (eff_interval - INTERVAL_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            duty_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (!ramp_en) begin
            state    <= IDLE;
            cnt      <= '0;
            duty_out <= target_duty;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (hold) begin
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (duty_out != target_duty) begin
                        state <= RAMP;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RAMP: begin
                    done <= 1'b0;
                    if (step_evt) begin
                        cnt      <= '0;
                        duty_out <= next_duty;
                        // Covers both a normal final step and a target that
                        // moved onto the current duty (next_duty == duty_out).
                        if (next_duty == target_duty) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + INTERVAL_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench for pwm_ramp_controller: directed scenarios plus
// randomized stimulus, all checked against a behavioural model.
module tb_pwm_ramp_controller;

    localparam int INTERVAL_W = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  ramp_en;
    logic                  hold;
    logic [7:0]            target_duty;
    logic [7:0]            step_size;
    logic [INTERVAL_W-1:0] interval;
    logic [7:0]            duty_out;
    logic                  busy;
    logic                  done;

    pwm_ramp_controller #(.INTERVAL_W(INTERVAL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ramp_en     (ramp_en),
        .hold        (hold),
        .target_duty (target_duty),
        .step_size   (step_size),
        .interval    (interval),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: current duty, whether a ramp is in progress, edges
    // elapsed since the ramp began or since the last step, and the done pulse.
    int m_duty    = 0;
    bit m_ramping = 0;
    int m_elapsed = 0;
    bit m_done    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Apply one rising edge to the model using the inputs present at the edge.
    task automatic model_edge();
        int tgt, ei, es, nd;
        tgt = int'(target_duty);
        ei  = max_i(int'(interval), 1);
        es  = max_i(int'(step_size), 1);
        if (!rst_n) begin
            m_duty = 0; m_ramping = 0; m_elapsed = 0; m_done = 0;
        end else if (!ramp_en) begin
            m_duty = tgt; m_ramping = 0; m_elapsed = 0; m_done = 0;
        end else if (hold) begin
            m_done = 0;
        end else if (!m_ramping) begin
            m_done = 0;
            if (m_duty != tgt) begin
                m_ramping = 1;
                m_elapsed = 0;
            end
        end else begin
            m_done = 0;
            if (m_elapsed + 1 >= ei) begin
                m_elapsed = 0;
                if (m_duty < tgt)      nd = min_i(m_duty + es, tgt);
                else if (m_duty > tgt) nd = max_i(m_duty - es, tgt);
                else                   nd = m_duty;
                m_duty = nd;
                if (nd == tgt) begin
                    m_ramping = 0;
                    m_done    = 1;
                end
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_duty"}, int'(duty_out), m_duty);
        check({tag, "_busy"}, int'(busy), int'(m_ramping));
        check({tag, "_done"}, int'(done), int'(m_done));
    endtask

    task automatic set_in(input bit en, input bit hd, input int tgt, input int st, input int iv);
        ramp_en     = en;
        hold        = hd;
        target_duty = 8'(tgt);
        step_size   = 8'(st);
        interval    = INTERVAL_W'(iv);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 1, 1);
        tick("reset");
        tick("reset");
        check("reset_duty_zero", int'(duty_out), 0);
        rst_n = 1'b1;

        // Reset in the middle of a ramp 0x40 -> 0x80.
        set_in(0, 0, 8'h40, 1, 2);
        tick("rst_mid_pre");
        set_in(1, 0, 8'h80, 1, 2);
        for (int i = 0; i < 6; i++) tick("rst_mid_ramp");
        check("rst_mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        tick("rst_mid_reset");
        check("rst_mid_duty0", int'(duty_out), 0);
        check("rst_mid_busy0", int'(busy), 0);
        check("rst_mid_done0", int'(done), 0);
        rst_n = 1'b1;

        // Up-ramp 0 -> 0x30, step 0x10, interval 4.
        set_in(0, 0, 0, 8'h10, 4);
        tick("up_pre");
        set_in(1, 0, 8'h30, 8'h10, 4);
        tick("up_entry");
        check("up_entry_busy", int'(busy), 1);
        for (int i = 1; i <= 12; i++) begin
            tick("up_ramp");
            if (i == 4)  check("up_c4",  int'(duty_out), 8'h10);
            if (i == 8)  check("up_c8",  int'(duty_out), 8'h20);
            if (i == 12) begin
                check("up_c12", int'(duty_out), 8'h30);
                check("up_c12_done", int'(done), 1);
                check("up_c12_busy", int'(busy), 0);
            end
        end
        tick("up_after");
        check("up_done_pulse_ends", int'(done), 0);

        // Saturation at the top and bottom.
        set_in(0, 0, 8'hF8, 8'h10, 1);
        tick("sat_pre");
        set_in(1, 0, 8'hFF, 8'h10, 1);
        tick("sat_entry");
        tick("sat_step");
        check("sat_top", int'(duty_out), 8'hFF);
        set_in(0, 0, 8'h05, 8'h10, 1);
        tick("sat_pre2");
        set_in(1, 0, 8'h00, 8'h10, 1);
        tick("sat_entry2");
        tick("sat_step2");
        check("sat_bottom", int'(duty_out), 0);

        // Zero step and zero interval: one-unit steps every cycle.
        set_in(0, 0, 0, 0, 0);
        tick("zero_pre");
        set_in(1, 0, 3, 0, 0);
        tick("zero_entry");
        for (int i = 1; i <= 3; i++) begin
            tick("zero_step");
            check("zero_duty", int'(duty_out), i);
        end
        check("zero_done", int'(done), 1);

        // Hold mid-ramp, then abort via ramp_en low.
        set_in(0, 0, 0, 8'h08, 3);
        tick("hold_pre");
        set_in(1, 0, 8'hA0, 8'h08, 3);
        for (int i = 0; i < 5; i++) tick("hold_ramp");
        hold = 1'b1;
        for (int i = 0; i < 10; i++) tick("hold_frozen");
        hold = 1'b0;
        tick("hold_release");
        ramp_en = 1'b0;
        tick("abort");
        check("abort_duty", int'(duty_out), 8'hA0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);

        // Retarget downward mid-ramp.
        set_in(0, 0, 0, 8'h20, 2);
        tick("ret_pre");
        set_in(1, 0, 8'h80, 8'h20, 2);
        for (int i = 0; i < 5; i++) tick("ret_up");
        check("ret_at40", int'(duty_out), 8'h40);
        target_duty = 8'h20;
        tick("ret_wait");
        tick("ret_step");
        check("ret_duty", int'(duty_out), 8'h20);
        check("ret_done", int'(done), 1);

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(199) != 0);
            if ($urandom_range(19) == 0) ramp_en = ~ramp_en;
            if ($urandom_range(99) < 93) ramp_en = ramp_en | ($urandom_range(3) != 0);
            hold = ($urandom_range(9) == 0);
            if ($urandom_range(24) == 0) target_duty = 8'($urandom);
            if ($urandom_range(49) == 0) step_size = 8'($urandom_range(64));
            if ($urandom_range(49) == 0) interval = INTERVAL_W'($urandom_range(5));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 Parameter INTERVAL_W, default 16, width of the step-interval count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ramp_en  input  1  1 = ramp toward target; 0 = bypass, output tracks target directly.
REQ-005 hold  input  1  1 = freeze ramp (counter and duty hold).
REQ-006 target_duty  input  8  requested duty cycle, sampled live every cycle.
REQ-007 step_size  input  8  duty increment/decrement per step; 0 treated as 1.
REQ-008 interval  input  INTERVAL_W  clock cycles per step; 0 treated as 1.
REQ-009 duty_out  output  8  registered duty cycle driven to the PWM peripheral.
REQ-010 busy  output  1  registered; 1 while in RAMP.
REQ-011 done  output  1  registered one-cycle pulse when a ramp completes.

Function
REQ-012 The block SHALL implement two states, IDLE and RAMP, plus an INTERVAL_W-bit interval counter (cnt).
REQ-013 With ramp_en=0, the block SHALL load duty_out <= target_duty every cycle (1-cycle latency), force state IDLE, cnt=0, busy=0, done=0.
REQ-014 In IDLE with ramp_en=1, hold=0 and duty_out != target_duty, the block SHALL enter RAMP with cnt=0; busy SHALL be 1 from the next cycle.
REQ-015 In IDLE with duty_out == target_duty, the block SHALL remain in IDLE and hold duty_out.
REQ-016 In RAMP with hold=0, cnt SHALL increment each cycle; when cnt == eff_interval-1 (eff_interval = max(interval,1)), a step event SHALL occur on that edge and cnt SHALL return to 0.
REQ-017 Consequence: the first step lands eff_interval cycles after RAMP entry, then every eff_interval cycles.
REQ-018 On a step with duty_out < target_duty, duty_out SHALL become min(duty_out + eff_step, target_duty), computed in 9 bits; no wrap past 255.
REQ-019 On a step with duty_out > target_duty, duty_out SHALL become max(duty_out - eff_step, target_duty), computed in 9 bits signed; no wrap below 0.
REQ-020 eff_step SHALL be max(step_size,1).
REQ-021 If a step's new duty_out equals target_duty, the block SHALL return to IDLE on the same edge, deassert busy and assert done for exactly one cycle.
REQ-022 target_duty changes during RAMP SHALL take effect at the next step event (direction re-evaluated); cnt SHALL NOT restart.
REQ-023 If target_duty equals duty_out at a step event without a step applied (target moved onto current value), the block SHALL go IDLE and pulse done.
REQ-024 hold=1 SHALL freeze cnt, duty_out and state in both states; hold is ignored when ramp_en=0 (bypass wins).
REQ-025 ramp_en falling during RAMP SHALL abort: IDLE next edge, busy=0, no done pulse, bypass per REQ-013.
REQ-026 interval changing during RAMP SHALL apply immediately; if cnt >= eff_interval-1, a step SHALL occur on the next edge.
REQ-027 done and a new RAMP entry SHALL NOT coincide; re-entry requires at least one IDLE cycle.

Reset
REQ-028 While rst_n=0 at a clock edge: state=IDLE, cnt=0, duty_out=8'h00, busy=0, done=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-RAMP; first post-reset decisions use inputs sampled on the first edge with rst_n=1.

Verification
REQ-030 Reset mid-ramp: duty_out=0x40 ramping to 0x80, assert rst_n=0 one edge -> duty_out=0x00, busy=0, done=0 next cycle.
REQ-031 Up-ramp: ramp_en=1, interval=4, step=0x10, target=0x30 from 0 -> duty 0x10/0x20/0x30 at cycles 4/8/12 after RAMP entry, done pulse with 0x30, busy low.
REQ-032 Saturation: duty=0xF8, target=0xFF, step=0x10, interval=1 -> one step to 0xFF, no wrap; down from 0x05 to 0x00 step 0x10 -> 0x00, no wrap.
REQ-033 Zero params: step=0, interval=0, duty 0x00 -> target 0x03 -> duty 1,2,3 on consecutive cycles, done on third.
REQ-034 Hold/abort: hold=1 for 10 cycles mid-ramp -> duty and cnt frozen; then ramp_en=0 -> duty_out=target next cycle, busy=0, no done.
REQ-035 Retarget: ramping up 0x00->0x80 step 0x20, at duty 0x40 set target 0x20 -> next step gives 0x20, done pulse.
